tx_phase_decoder: RTL and testbench

Converts per-channel transmit phase codes from decimal "tens of degrees" form (0, 9, 18, 27 = 0°, 90°, 180°, 270°) into 2-bit quadrature phase selects for the TX phase-shift stage. It handles N_phases independent lanes packed into one bus and registers the result once. It sits between the host-written pulse-sequence registers and the TX NCO/phase mux.

---
 rtl/tx_phase_decoder_if.sv | 21 ++
 rtl/tx_phase_decoder.sv | 51 +++++
 tb/tb_tx_phase_decoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/tx_phase_decoder_if.sv
// Phase-code bus between the pulse-sequence registers and the TX phase decoder.
// Lane i occupies bits [5i+4:5i] of phase_decimal and bits [2i+1:2i] of phase_binary.
interface tx_phase_decoder_if #(
    parameter int unsigned N_phases = 3
);
    logic [5*N_phases-1:0] phase_decimal;
    logic [2*N_phases-1:0] phase_binary;
    logic [N_phases-1:0]   phase_error;

    modport master (
        output phase_decimal,
        input  phase_binary,
        input  phase_error
    );

    modport slave (
        input  phase_decimal,
        output phase_binary,
        output phase_error
    );
endinterface

// File: rtl/tx_phase_decoder.sv
// Decodes per-lane "tens of degrees" phase codes (0/9/18/27) into registered 2-bit
// quadrature selects, flagging any other code as an error on that lane only.
module tx_phase_decoder #(
    parameter int unsigned N_phases = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    tx_phase_decoder_if.slave   bus
);

    logic [2*N_phases-1:0] phase_binary_d, phase_binary_q;
    logic [N_phases-1:0]   phase_error_d, phase_error_q;

    for (genvar i = 0; i < N_phases; i++) begin : g_lane
        logic [4:0] code;
        logic [1:0] lane_bin;
        logic       lane_err;

        assign code = bus.phase_decimal[5*i +: 5];

        // Exact matches only; near values such as 10 are errors, not rounded.
        always_comb begin
            lane_bin = 2'b00;
            lane_err = 1'b0;
            unique case (code)
                5'd0:    lane_bin = 2'b00;
                5'd9:    lane_bin = 2'b01;
                5'd18:   lane_bin = 2'b10;
                5'd27:   lane_bin = 2'b11;
                default: lane_err = 1'b1;
            endcase
        end

        assign phase_binary_d[2*i +: 2] = lane_bin;
        assign phase_error_d[i]         = lane_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_binary_q <= '0;
            phase_error_q  <= '0;
        end else begin
            phase_binary_q <= phase_binary_d;
            phase_error_q  <= phase_error_d;
        end
    end

    assign bus.phase_binary = phase_binary_q;
    assign bus.phase_error  = phase_error_q;

endmodule

// File: tb/tb_tx_phase_decoder.sv
// Bench for tx_phase_decoder: directed and random phase codes on a 3-lane and a 1-lane
// instance, checked one cycle later against an arithmetic model of the decode rules.
module tb_tx_phase_decoder;

    logic clk;
    logic rst_n;

    int unsigned n_vec;
    int unsigned n_miscompare;

    tx_phase_decoder_if #(.N_phases(3)) bus3 ();
    tx_phase_decoder_if #(.N_phases(1)) bus1 ();

    tx_phase_decoder #(.N_phases(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    tx_phase_decoder #(.N_phases(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_val);
        n_vec++;
        if (obs !== exp_val) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end
    endtask

    // A code is legal iff it is a multiple of 9 no larger than 27; the select is code/9.
    function automatic void ref_lane(input logic [4:0] c, output logic [1:0] b, output logic e);
        int ci;
        ci = int'(c);
        if (ci <= 27 && ci % 9 == 0) begin
            b = 2'(ci / 9);
            e = 1'b0;
        end else begin
            b = 2'b00;
            e = 1'b1;
        end
    endfunction

    // Apply inputs at a falling edge, let one rising edge register them, check at the next fall.
    task automatic step(input logic rst, input logic [14:0] d3, input logic [4:0] d1,
                        input string tag);
        logic [5:0] eb3;
        logic [2:0] ee3;
        logic [1:0] eb1;
        logic       ee1;
        logic [1:0] b;
        logic       e;
        rst_n              = rst;
        bus3.phase_decimal = d3;
        bus1.phase_decimal = d1;
        @(posedge clk);
        @(negedge clk);
        eb3 = '0;
        ee3 = '0;
        for (int k = 0; k < 3; k++) begin
            ref_lane(d3[5*k +: 5], b, e);
            eb3[2*k +: 2] = b;
            ee3[k]        = e;
        end
        ref_lane(d1, eb1, ee1);
        if (!rst) begin
            eb3 = '0;
            ee3 = '0;
            eb1 = '0;
            ee1 = 1'b0;
        end
        check_eq({tag, "_bin3"}, 16'(bus3.phase_binary), 16'(eb3));
        check_eq({tag, "_err3"}, 16'(bus3.phase_error), 16'(ee3));
        check_eq({tag, "_bin1"}, 16'(bus1.phase_binary), 16'(eb1));
        check_eq({tag, "_err1"}, 16'(bus1.phase_error), 16'(ee1));
    endtask

    function automatic logic [4:0] rand_code();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3) * 9);
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        rst_n              = 1'b0;
        bus3.phase_decimal = '0;
        bus1.phase_decimal = '0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(1'b0, {5'd27, 5'd27, 5'd27}, 5'd27, "reset");

        step(1'b1, {5'd0,  5'd9,  5'd18}, 5'd0,  "seq_a");
        step(1'b1, {5'd9,  5'd18, 5'd27}, 5'd9,  "seq_b");
        step(1'b1, {5'd27, 5'd27, 5'd9},  5'd18, "seq_c");
        step(1'b0, {5'd27, 5'd9,  5'd18}, 5'd27, "mid_reset");
        step(1'b1, {5'd0,  5'd9,  5'd0},  5'd27, "seq_d");
        step(1'b1, {5'd10, 5'd9,  5'd31}, 5'd5,  "invalid");
        step(1'b1, {5'd1,  5'd26, 5'd28}, 5'd8,  "near");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) != 0),
                 {rand_code(), rand_code(), rand_code()}, rand_code(), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
